mipi_rx_frame_sequencer: RTL

//  Frame-level controller for the MIPI CSI-2 RX payload path. Tracks FS/FE short packets and pixel long packets,
//  and gates each 32-bit payload beat into the downstream line FIFO. Checks word counts and lines per frame, and

---
 rtl/mipi_rx_frame_sequencer_if.sv | 24 ++
 rtl/mipi_rx_frame_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_frame_sequencer_if.sv
// CSI-2 RX packet/payload bus and downstream line-FIFO write port for the frame sequencer.
interface mipi_rx_frame_sequencer_if;
    logic [5:0]  Rx_cmd_data_type;
    logic [15:0] Rx_cmd_word_count;
    logic        Rx_cmd_valid;
    logic [31:0] Rx_payload;
    logic        Rx_payload_valid;
    logic        Rx_payload_valid_last;
    logic        fifo_full;
    logic        fifo_writeen;
    logic [31:0] fifo_din;

    modport master (
        output Rx_cmd_data_type, Rx_cmd_word_count, Rx_cmd_valid,
        output Rx_payload, Rx_payload_valid, Rx_payload_valid_last, fifo_full,
        input  fifo_writeen, fifo_din
    );

    modport slave (
        input  Rx_cmd_data_type, Rx_cmd_word_count, Rx_cmd_valid,
        input  Rx_payload, Rx_payload_valid, Rx_payload_valid_last, fifo_full,
        output fifo_writeen, fifo_din
    );
endinterface

// File: rtl/mipi_rx_frame_sequencer.sv
// CSI-2 RX frame sequencer: FS/FE/pixel-packet tracking, gated line-FIFO writes, word/line checks.
// Optional row cropping is enabled by defining MIPI_SEQ_CROP_EN.
//
// state    | meaning
// IDLE     | capture disabled
// WAIT_FS  | armed, waiting for frame start
// WAIT_PKT | inside a frame, between packets
// PAYLOAD  | forwarding pixel beats to the FIFO
// DROP     | discarding the rest of a pixel packet
module mipi_rx_frame_sequencer #(
    parameter logic [5:0]  PIX_DT    = 6'h3E,
    parameter logic [10:0] HEIGHT    = 11'd1440,
    parameter logic [10:0] ROW_START = 11'd0
) (
    input  logic                             CLKn,
    input  logic                             RST,
    input  logic                             ctrl_enable,
    input  logic                             err_clr,
    mipi_rx_frame_sequencer_if.slave         bus,
    output logic                             frame_start,
    output logic                             frame_end,
    output logic [10:0]                      line_cnt,
    output logic                             busy,
    output logic                             err_wc,
    output logic                             err_lines,
    output logic                             err_ovf
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_FS  = 3'd1;
    localparam logic [2:0] S_WAIT_PKT = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_DROP     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [14:0] beat_cnt_q, beat_cnt_d;
    logic [14:0] exp_beats_q, exp_beats_d;
    logic        fs_pulse_q, fs_pulse_d;
    logic        fe_pulse_q, fe_pulse_d;
    logic        wr_q, wr_d;
    logic [31:0] din_q, din_d;
    logic        err_wc_q, err_lines_q, err_ovf_q;
    logic        set_wc, set_lines, set_ovf;

    logic        is_fs, is_fe, is_pix, beat, last;
    logic [10:0] line_inc;
    logic [14:0] beat_next;
    logic        in_window;
    logic [11:0] lines_target;

    assign is_fs     = bus.Rx_cmd_valid && (bus.Rx_cmd_data_type == 6'h00);
    assign is_fe     = bus.Rx_cmd_valid && (bus.Rx_cmd_data_type == 6'h01);
    assign is_pix    = bus.Rx_cmd_valid && (bus.Rx_cmd_data_type == PIX_DT);
    assign beat      = bus.Rx_payload_valid;
    assign last      = bus.Rx_payload_valid && bus.Rx_payload_valid_last;
    assign line_inc  = (line_cnt_q == 11'h7FF) ? line_cnt_q : line_cnt_q + 11'd1;
    assign beat_next = beat_cnt_q + 15'd1;

`ifdef MIPI_SEQ_CROP_EN
    assign lines_target = {1'b0, ROW_START} + {1'b0, HEIGHT};
    assign in_window    = (line_cnt_q >= ROW_START) && ({1'b0, line_cnt_q} < lines_target);
`else
    logic unused_row_start;
    assign unused_row_start = ^ROW_START;
    assign lines_target     = {1'b0, HEIGHT};
    assign in_window        = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        exp_beats_d = exp_beats_q;
        fs_pulse_d  = 1'b0;
        fe_pulse_d  = 1'b0;
        wr_d        = 1'b0;
        din_d       = din_q;
        set_wc      = 1'b0;
        set_lines   = 1'b0;
        set_ovf     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_enable) state_d = S_WAIT_FS;
            end
            S_WAIT_FS: begin
                if (is_fs) begin
                    state_d    = S_WAIT_PKT;
                    fs_pulse_d = 1'b1;
                    line_cnt_d = 11'd0;
                end else if (!ctrl_enable) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_PKT: begin
                if (is_fs) begin
                    fs_pulse_d = 1'b1;
                    line_cnt_d = 11'd0;
                end else if (is_pix) begin
                    exp_beats_d = 15'((17'(bus.Rx_cmd_word_count) + 17'd3) >> 2);
                    beat_cnt_d  = 15'd0;
                    state_d     = in_window ? S_PAYLOAD : S_DROP;
                end else if (is_fe) begin
                    fe_pulse_d = 1'b1;
                    set_lines  = ({1'b0, line_cnt_q} != lines_target);
                    state_d    = ctrl_enable ? S_WAIT_FS : S_IDLE;
                end
            end
            S_PAYLOAD, S_DROP: begin
                // A new FS abandons the packet in flight and restarts the frame.
                if (is_fs) begin
                    set_wc     = 1'b1;
                    fs_pulse_d = 1'b1;
                    line_cnt_d = 11'd0;
                    state_d    = S_WAIT_PKT;
                end else if (beat) begin
                    beat_cnt_d = beat_next;
                    if (state_q == S_PAYLOAD) begin
                        if (bus.fifo_full) begin
                            set_ovf = 1'b1;
                            state_d = S_DROP;
                        end else begin
                            wr_d  = 1'b1;
                            din_d = bus.Rx_payload;
                        end
                        if (last) set_wc = (beat_next != exp_beats_q);
                    end
                    if (last) begin
                        state_d    = S_WAIT_PKT;
                        line_cnt_d = line_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLKn) begin
        if (RST) begin
            state_q     <= S_IDLE;
            line_cnt_q  <= 11'd0;
            beat_cnt_q  <= 15'd0;
            exp_beats_q <= 15'd0;
            fs_pulse_q  <= 1'b0;
            fe_pulse_q  <= 1'b0;
            wr_q        <= 1'b0;
            din_q       <= 32'd0;
            err_wc_q    <= 1'b0;
            err_lines_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_beats_q <= exp_beats_d;
            fs_pulse_q  <= fs_pulse_d;
            fe_pulse_q  <= fe_pulse_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
            // Set has priority over a simultaneous clear.
            err_wc_q    <= set_wc    | (err_wc_q    & ~err_clr);
            err_lines_q <= set_lines | (err_lines_q & ~err_clr);
            err_ovf_q   <= set_ovf   | (err_ovf_q   & ~err_clr);
        end
    end

    assign bus.fifo_writeen = wr_q;
    assign bus.fifo_din     = din_q;
    assign frame_start      = fs_pulse_q;
    assign frame_end        = fe_pulse_q;
    assign line_cnt         = line_cnt_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_WAIT_FS);
    assign err_wc           = err_wc_q;
    assign err_lines        = err_lines_q;
    assign err_ovf          = err_ovf_q;
endmodule
